// File: rtl/cra_pkg.sv
// Shared CRAM definitions: address type, dispatch codes and sequencer defaults.
package cra_pkg;

  typedef logic [10:0] tCramAdr;

  typedef enum logic [4:0] {
    DISP_DIAG      = 5'o00,
    DISP_DRAM_J    = 5'o01,
    DISP_DRAM_A_RD = 5'o02,
    DISP_RETURN    = 5'o03,
    DISP_PG_FAIL   = 5'o04,
    DISP_SR        = 5'o05,
    DISP_NICOND    = 5'o06,
    DISP_SH0_3     = 5'o07,
    DISP_MUL       = 5'o30,
    DISP_DIV       = 5'o31,
    DISP_SIGNS     = 5'o32,
    DISP_DRAM_B    = 5'o33,
    DISP_BYTE      = 5'o34,
    DISP_NORM      = 5'o35,
    DISP_EA_MOD    = 5'o36
  } tDisp;

  localparam int unsigned CRA_STACK_DEPTH = 16;
  localparam tCramAdr     CRA_PF_TRAP_ADR = 11'o1777;

endpackage

// File: rtl/cra_if.sv
// Microword fields, dispatch/skip operands, diagnostic controls and CRA outputs.
interface cra_if;
  import cra_pkg::*;

  logic        CRA_advance;
  tCramAdr     CRAM_J;
  logic [4:0]  CRAM_DISP;
  logic [5:0]  CRAM_SKIP;
  logic        CRAM_CALL;
  logic [63:0] CRA_skipConds;
  logic [3:0]  CRA_dispData;
  tCramAdr     DRAM_J;
  logic [2:0]  DRAM_A;
  logic        CRA_pageFail;
  logic        CRA_diagLoad;
  tCramAdr     CRA_diagAdr;
  logic        CRA_diagReset;
  tCramAdr     CRA_ADR;
  logic [4:0]  CRA_callDepth;
  logic        CRA_stackErr;

  modport master (
    output CRA_advance, CRAM_J, CRAM_DISP, CRAM_SKIP, CRAM_CALL, CRA_skipConds,
           CRA_dispData, DRAM_J, DRAM_A, CRA_pageFail, CRA_diagLoad, CRA_diagAdr,
           CRA_diagReset,
    input  CRA_ADR, CRA_callDepth, CRA_stackErr
  );

  modport slave (
    input  CRA_advance, CRAM_J, CRAM_DISP, CRAM_SKIP, CRAM_CALL, CRA_skipConds,
           CRA_dispData, DRAM_J, DRAM_A, CRA_pageFail, CRA_diagLoad, CRA_diagAdr,
           CRA_diagReset,
    output CRA_ADR, CRA_callDepth, CRA_stackErr
  );

endinterface

// File: rtl/cra_stack.sv
// Microcode return stack: circular LIFO with combinational top, depth count and
// sticky overflow/underflow flag. STACK_DEPTH must be a power of two >= 2.
module cra_stack
  import cra_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = CRA_STACK_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  tCramAdr                      wdata_i,
  output tCramAdr                      top_o,
  output logic [$clog2(STACK_DEPTH):0] depth_o,
  output logic                         err_o
);

  localparam int unsigned PW = $clog2(STACK_DEPTH);

  tCramAdr       mem_q [STACK_DEPTH];
  logic [PW-1:0] sp_q, sp_d, top_idx, wr_idx;
  logic [PW:0]   depth_q, depth_d;
  logic          err_q, err_d, wr_en, full, empty;

  assign top_idx = sp_q - PW'(1);
  assign full    = (depth_q == (PW+1)'(STACK_DEPTH));
  assign empty   = (depth_q == '0);

  // Overflow keeps advancing sp so the wrapped write lands on the oldest slot.
  always_comb begin
    sp_d    = sp_q;
    depth_d = depth_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_idx  = sp_q;
    if (push_i && pop_i) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
      if (empty) err_d = 1'b1;
    end else if (push_i) begin
      wr_en = 1'b1;
      sp_d  = sp_q + PW'(1);
      if (full) err_d = 1'b1;
      else      depth_d = depth_q + (PW+1)'(1);
    end else if (pop_i) begin
      if (empty) err_d = 1'b1;
      else begin
        sp_d    = top_idx;
        depth_d = depth_q - (PW+1)'(1);
      end
    end
    if (clr_i) begin
      sp_d    = '0;
      depth_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q    <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_idx] <= wdata_i;
  end

  assign top_o   = mem_q[top_idx];
  assign depth_o = depth_q;
  assign err_o   = err_q;

endmodule

// File: rtl/cra.sv
// CRAM address sequencer: next-address mux, skip merge, call/return stack
// control, page-fail trap and diagnostic load feeding the CRA_ADR register.
module cra
  import cra_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = CRA_STACK_DEPTH,
  parameter tCramAdr     PF_TRAP_ADR = CRA_PF_TRAP_ADR
) (
  input  logic  eboxClk,
  input  logic  eboxReset_n,
  cra_if.slave  bus
);

  tCramAdr                      adr_q, adr_d, base, top;
  logic                         skip_hit, push, pop, stk_err;
  logic [$clog2(STACK_DEPTH):0] depth;

  // Bit 10 is the LSB in DEC numbering; field merges OR into the low bits.
  always_comb begin
    base = bus.CRAM_J;
    case (tDisp'(bus.CRAM_DISP))
      DISP_DRAM_J:    base = (bus.CRAM_J & 11'o2000) | (bus.DRAM_J & 11'o1777);
      DISP_DRAM_A_RD: base = bus.CRAM_J | {8'b0, bus.DRAM_A};
      DISP_RETURN:    base = top | bus.CRAM_J;
      DISP_NICOND, DISP_SH0_3, DISP_MUL, DISP_DIV, DISP_SIGNS,
      DISP_BYTE, DISP_NORM, DISP_EA_MOD:
                      base = bus.CRAM_J | {7'b0, bus.CRA_dispData};
      default:        base = bus.CRAM_J;
    endcase
  end

  assign skip_hit = (bus.CRAM_SKIP != '0) && bus.CRA_skipConds[bus.CRAM_SKIP];

  always_comb begin
    adr_d = adr_q;
    push  = 1'b0;
    pop   = 1'b0;
    if (bus.CRA_advance) begin
      if (bus.CRA_diagLoad) begin
        adr_d = bus.CRA_diagAdr;
      end else if (bus.CRA_pageFail) begin
        adr_d = PF_TRAP_ADR;
        push  = 1'b1;
      end else begin
        adr_d = base | {10'b0, skip_hit};
        push  = bus.CRAM_CALL;
        pop   = (tDisp'(bus.CRAM_DISP) == DISP_RETURN);
      end
    end
  end

  always_ff @(posedge eboxClk or negedge eboxReset_n) begin
    if (!eboxReset_n) adr_q <= '0;
    else              adr_q <= adr_d;
  end

  cra_stack #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk_i   (eboxClk),
    .rst_ni  (eboxReset_n),
    .clr_i   (bus.CRA_diagReset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (adr_q),
    .top_o   (top),
    .depth_o (depth),
    .err_o   (stk_err)
  );

  assign bus.CRA_ADR       = adr_q;
  assign bus.CRA_callDepth = 5'(depth);
  assign bus.CRA_stackErr  = stk_err;

endmodule
